// File: rtl/boot_loader_if.sv
// boot_loader_if - byte-stream valid/ready handshake into the boot loader.
// The byte source drives in_valid/in_data as master; the loader drives in_ready as slave.
interface boot_loader_if;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready;

    modport master (output in_valid, output in_data, input in_ready);
    modport slave  (input in_valid, input in_data, output in_ready);
endinterface

// File: rtl/boot_loader.sv
// boot_loader - loads a boot image from a byte stream into instruction memory.
// Stream: count_lo, count_hi (word count N), then 4*N bytes, words little-endian.
// The CPU reset is held until the image has been written; it is released one
// cycle after done rises. Words beyond 2^ADDR_W are consumed but not written
// and end the load in ERROR. ADDR_W must not exceed 16.
// Optional feature: define BOOT_CHECKSUM_EN to require a trailing XOR checksum
// byte over all data bytes (seed 0x00); a mismatch ends the load in ERROR.
module boot_loader #(
    parameter int unsigned ADDR_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    boot_loader_if.slave      stream,
    input  logic              restart,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              cpu_reset,
    output logic              done,
    output logic              err
);

`ifdef BOOT_CHECKSUM_EN
    typedef enum logic [2:0] {S_HDR_LO, S_HDR_HI, S_DATA, S_CSUM, S_DONE, S_ERROR} state_t;
`else
    typedef enum logic [2:0] {S_HDR_LO, S_HDR_HI, S_DATA, S_DONE, S_ERROR} state_t;
`endif

    state_t      state_q, state_d;
    logic [15:0] count_q;
    logic [15:0] word_idx_q;
    logic [1:0]  byte_cnt_q;
    logic [23:0] asm_q;
    logic        ovf_q;
`ifdef BOOT_CHECKSUM_EN
    logic [7:0]  csum_q;
`endif

    logic fire;
    logic take_restart;
    logic last_byte;
    logic last_word;
    logic word_ovf;

    assign stream.in_ready = (state_q != S_DONE) && (state_q != S_ERROR);
    assign fire            = stream.in_valid && stream.in_ready;
    assign take_restart    = restart && ((state_q == S_DONE) || (state_q == S_ERROR));
    assign last_byte       = (byte_cnt_q == 2'd3);
    assign last_word       = (word_idx_q == count_q - 16'd1);
    assign word_ovf        = (word_idx_q >> ADDR_W) != '0;
    assign done            = (state_q == S_DONE);
    assign err             = (state_q == S_ERROR);

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= S_HDR_LO;
        else        state_q <= state_d;
    end

    // Next-state decode: header, data words, optional checksum, then terminal states.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_HDR_LO: if (fire) state_d = S_HDR_HI;
            S_HDR_HI: begin
                if (fire) begin
                    if ({stream.in_data, count_q[7:0]} == 16'd0) begin
`ifdef BOOT_CHECKSUM_EN
                        state_d = S_CSUM;
`else
                        state_d = S_DONE;
`endif
                    end else begin
                        state_d = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (fire && last_byte && last_word) begin
`ifdef BOOT_CHECKSUM_EN
                    state_d = S_CSUM;
`else
                    state_d = (ovf_q || word_ovf) ? S_ERROR : S_DONE;
`endif
                end
            end
`ifdef BOOT_CHECKSUM_EN
            S_CSUM: begin
                if (fire) state_d = (ovf_q || (stream.in_data != csum_q)) ? S_ERROR : S_DONE;
            end
`endif
            S_DONE:  if (restart) state_d = S_HDR_LO;
            S_ERROR: if (restart) state_d = S_HDR_LO;
            default: state_d = S_HDR_LO;
        endcase
    end

    // Datapath: header capture, word assembly, memory write strobe, overflow flag.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q    <= '0;
            word_idx_q <= '0;
            byte_cnt_q <= '0;
            asm_q      <= '0;
            ovf_q      <= 1'b0;
            imem_we    <= 1'b0;
            imem_addr  <= '0;
            imem_wdata <= '0;
`ifdef BOOT_CHECKSUM_EN
            csum_q     <= '0;
`endif
        end else begin
            imem_we <= 1'b0;
            if (take_restart) begin
                word_idx_q <= '0;
                byte_cnt_q <= '0;
                ovf_q      <= 1'b0;
`ifdef BOOT_CHECKSUM_EN
                csum_q     <= '0;
`endif
            end else if (fire) begin
                case (state_q)
                    S_HDR_LO: count_q[7:0]  <= stream.in_data;
                    S_HDR_HI: count_q[15:8] <= stream.in_data;
                    S_DATA: begin
                        byte_cnt_q <= byte_cnt_q + 2'd1;
                        asm_q      <= {stream.in_data, asm_q[23:8]};
`ifdef BOOT_CHECKSUM_EN
                        csum_q     <= csum_q ^ stream.in_data;
`endif
                        if (last_byte) begin
                            if (word_ovf) begin
                                ovf_q <= 1'b1;
                            end else begin
                                imem_we    <= 1'b1;
                                imem_addr  <= word_idx_q[ADDR_W-1:0];
                                imem_wdata <= {stream.in_data, asm_q};
                            end
                            word_idx_q <= word_idx_q + 16'd1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    // CPU reset: released only after a full cycle in DONE, reasserted on restart.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) cpu_reset <= 1'b1;
        else        cpu_reset <= !((state_q == S_DONE) && !restart);
    end

endmodule

// File: tb/tb_boot_loader.sv
// tb_boot_loader - directed streams into two loaders (ADDR_W=8 and ADDR_W=2)
// fed with identical inputs, checked every cycle against a byte-position model.
module tb_boot_loader;

    typedef logic [7:0] bq_t[$];

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       restart = 1'b0;
    logic       in_valid = 1'b0;
    logic [7:0] in_data = 8'h00;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    boot_loader_if s8 ();
    boot_loader_if s2 ();

    assign s8.in_valid = in_valid;
    assign s8.in_data  = in_data;
    assign s2.in_valid = in_valid;
    assign s2.in_data  = in_data;

    logic        we8, we2, cr8, cr2, dn8, dn2, er8, er2;
    logic [7:0]  a8;
    logic [1:0]  a2;
    logic [31:0] d8, d2;

    boot_loader #(.ADDR_W(8)) u8 (
        .clk(clk), .reset(reset), .stream(s8.slave), .restart(restart),
        .imem_we(we8), .imem_addr(a8), .imem_wdata(d8),
        .cpu_reset(cr8), .done(dn8), .err(er8)
    );

    boot_loader #(.ADDR_W(2)) u2 (
        .clk(clk), .reset(reset), .stream(s2.slave), .restart(restart),
        .imem_we(we2), .imem_addr(a2), .imem_wdata(d2),
        .cpu_reset(cr2), .done(dn2), .err(er2)
    );

    logic        obs_we [2];
    logic [7:0]  obs_addr [2];
    logic [31:0] obs_data [2];
    logic        obs_dn [2];
    logic        obs_er [2];
    logic        obs_rdy [2];
    logic        obs_cr [2];

    assign obs_we[0]   = we8;
    assign obs_we[1]   = we2;
    assign obs_addr[0] = a8;
    assign obs_addr[1] = {6'd0, a2};
    assign obs_data[0] = d8;
    assign obs_data[1] = d2;
    assign obs_dn[0]   = dn8;
    assign obs_dn[1]   = dn2;
    assign obs_er[0]   = er8;
    assign obs_er[1]   = er2;
    assign obs_rdy[0]  = s8.in_ready;
    assign obs_rdy[1]  = s2.in_ready;
    assign obs_cr[0]   = cr8;
    assign obs_cr[1]   = cr2;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: tracks stream position and derives outputs from the stream format.
    int          depth [2] = '{256, 4};
    int          pos [2];
    int          nw [2];
    logic [31:0] wd [2];
    logic [7:0]  xs [2];
    bit          fin [2];
    bit          ferr [2];
    bit          ovf [2];
    bit          x_we [2];
    int          x_addr [2];
    logic [31:0] x_data [2];
    bit          x_cpu [2];

    // Per-edge model update, then compare against the DUT 1 ns after the edge.
    always @(posedge clk) begin
        logic       v, rs;
        logic [7:0] b;
        int         p, k, j;
        bit         was_done;
        v  = in_valid;
        b  = in_data;
        rs = restart;
        for (int d = 0; d < 2; d++) begin
            if (!reset) begin
                pos[d] = 0; nw[d] = 0; xs[d] = 8'h00; fin[d] = 0; ferr[d] = 0;
                ovf[d] = 0; x_we[d] = 0; x_cpu[d] = 1;
            end else begin
                was_done = fin[d] && !ferr[d];
                x_we[d]  = 0;
                if (fin[d]) begin
                    if (rs) begin
                        fin[d] = 0; ferr[d] = 0; pos[d] = 0; ovf[d] = 0; xs[d] = 8'h00;
                    end
                end else if (v) begin
                    p = pos[d];
                    if (p == 0) begin
                        nw[d] = int'(b);
                    end else if (p == 1) begin
                        nw[d] = nw[d] + 256 * int'(b);
                        if (nw[d] == 0) begin
`ifndef BOOT_CHECKSUM_EN
                            fin[d] = 1; ferr[d] = ovf[d];
`endif
                        end
                    end else if (p < 2 + 4 * nw[d]) begin
                        k = (p - 2) / 4;
                        j = (p - 2) % 4;
                        wd[d][8*j +: 8] = b;
                        xs[d] = xs[d] ^ b;
                        if (j == 3) begin
                            if (k < depth[d]) begin
                                x_we[d] = 1; x_addr[d] = k; x_data[d] = wd[d];
                            end else begin
                                ovf[d] = 1;
                            end
                            if (k == nw[d] - 1) begin
`ifndef BOOT_CHECKSUM_EN
                                fin[d] = 1; ferr[d] = ovf[d];
`endif
                            end
                        end
                    end else begin
                        fin[d] = 1;
                        ferr[d] = ovf[d] || (b != xs[d]);
                    end
                    pos[d] = p + 1;
                end
                x_cpu[d] = !(was_done && !rs);
            end
        end
        #1;
        if (reset) begin
            for (int d = 0; d < 2; d++) begin
                chk($sformatf("imem_we[%0d]", d), 32'(obs_we[d]), 32'(x_we[d]));
                if (x_we[d]) begin
                    chk($sformatf("imem_addr[%0d]", d), 32'(obs_addr[d]), 32'(x_addr[d]));
                    chk($sformatf("imem_wdata[%0d]", d), obs_data[d], x_data[d]);
                end
                chk($sformatf("done[%0d]", d), 32'(obs_dn[d]), 32'(fin[d] && !ferr[d]));
                chk($sformatf("err[%0d]", d), 32'(obs_er[d]), 32'(fin[d] && ferr[d]));
                chk($sformatf("in_ready[%0d]", d), 32'(obs_rdy[d]), 32'(!fin[d]));
                chk($sformatf("cpu_reset[%0d]", d), 32'(obs_cr[d]), 32'(x_cpu[d]));
            end
        end
    end

    // Capture of written words for literal spot checks.
    logic [31:0] mem8 [256];
    int          wr8 = 0;
    int          wr2 = 0;
    always @(posedge clk) begin
        if (we8) begin
            mem8[a8] <= d8;
            wr8      <= wr8 + 1;
        end
        if (we2) wr2 <= wr2 + 1;
    end

    function automatic bq_t mk(input logic [31:0] w[$]);
        bq_t        q;
        logic [7:0] x;
        logic [15:0] n;
        x = 8'h00;
        n = 16'(w.size());
        q.push_back(n[7:0]);
        q.push_back(n[15:8]);
        foreach (w[i]) begin
            for (int b = 0; b < 4; b++) begin
                q.push_back(w[i][8*b +: 8]);
                x = x ^ w[i][8*b +: 8];
            end
        end
`ifdef BOOT_CHECKSUM_EN
        q.push_back(x);
`endif
        return q;
    endfunction

    task automatic put(input logic [7:0] b, input bit thr);
        in_valid = 1'b1;
        in_data  = b;
        @(negedge clk);
        in_valid = 1'b0;
        in_data  = 8'($urandom);
        if (thr) @(negedge clk);
    endtask

    task automatic send(input bq_t q, input bit thr);
        foreach (q[i]) put(q[i], thr);
        repeat (3) @(negedge clk);
    endtask

    task automatic do_restart;
        restart = 1'b1;
        @(negedge clk);
        restart = 1'b0;
        chk("restart cpu_reset", 32'(cr8), 32'd1);
        chk("restart in_ready", 32'(s8.in_ready), 32'd1);
        chk("restart done", 32'(dn8), 32'd0);
        @(negedge clk);
    endtask

    initial begin
        bq_t s;
        int  b8, b2;

        repeat (2) @(negedge clk);
        chk("rst in_ready", 32'(s8.in_ready), 32'd1);
        chk("rst imem_we", 32'(we8), 32'd0);
        chk("rst imem_addr", 32'(a8), 32'd0);
        chk("rst imem_wdata", d8, 32'd0);
        chk("rst cpu_reset", 32'(cr8), 32'd1);
        chk("rst done", 32'(dn8), 32'd0);
        chk("rst err", 32'(er8), 32'd0);
        reset = 1'b1;
        @(negedge clk);

        // Partial word then asynchronous reset.
        put(8'h01, 0); put(8'h00, 0); put(8'hAA, 0); put(8'hBB, 0);
        reset = 1'b0;
        #1;
        chk("midrst cpu_reset", 32'(cr8), 32'd1);
        chk("midrst in_ready", 32'(s8.in_ready), 32'd1);
        chk("midrst imem_we", 32'(we8), 32'd0);
        chk("midrst done", 32'(dn8), 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        b8 = wr8;
        send(mk('{32'h00100013}), 0);
        chk("t1 word0", mem8[0], 32'h00100013);
        chk("t1 writes", 32'(wr8 - b8), 32'd1);
        chk("t1 done", 32'(dn8), 32'd1);

        do_restart();
        b8 = wr8;
        send(mk('{32'h00100093, 32'h00200113, 32'h002081B3}), 0);
        chk("t3 word0", mem8[0], 32'h00100093);
        chk("t3 word1", mem8[1], 32'h00200113);
        chk("t3 word2", mem8[2], 32'h002081B3);
        chk("t3 writes", 32'(wr8 - b8), 32'd3);
        chk("t3 cpu_reset", 32'(cr8), 32'd0);

        do_restart();
        b8 = wr8;
        send(mk('{32'h00100093, 32'h00200113, 32'h002081B3}), 1);
        chk("thr writes", 32'(wr8 - b8), 32'd3);
        chk("thr word2", mem8[2], 32'h002081B3);

        do_restart();
        // Restart outside DONE/ERROR must be ignored.
        restart = 1'b1;
        @(negedge clk);
        restart = 1'b0;
        b8 = wr8;
        s = {8'h00, 8'h00};
`ifdef BOOT_CHECKSUM_EN
        s.push_back(8'h00);
`endif
        send(s, 0);
        chk("n0 writes", 32'(wr8 - b8), 32'd0);
        chk("n0 done", 32'(dn8), 32'd1);

        do_restart();
        b8 = wr8;
        b2 = wr2;
        send(mk('{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444, 32'h55555555}), 0);
        chk("ovf writes2", 32'(wr2 - b2), 32'd4);
        chk("ovf err2", 32'(er2), 32'd1);
        chk("ovf cpu_reset2", 32'(cr2), 32'd1);
        chk("ovf in_ready2", 32'(s2.in_ready), 32'd0);
        chk("ovf writes8", 32'(wr8 - b8), 32'd5);
        chk("ovf done8", 32'(dn8), 32'd1);
        chk("ovf word4", mem8[4], 32'h55555555);

`ifdef BOOT_CHECKSUM_EN
        do_restart();
        send({8'h01, 8'h00, 8'h13, 8'h00, 8'h10, 8'h00, 8'h03}, 0);
        chk("csum ok done", 32'(dn8), 32'd1);
        do_restart();
        send({8'h01, 8'h00, 8'h13, 8'h00, 8'h10, 8'h00, 8'h04}, 0);
        chk("csum bad err", 32'(er8), 32'd1);
        chk("csum bad cpu_reset", 32'(cr8), 32'd1);
        do_restart();
        send({8'h01, 8'h00, 8'h13, 8'h00, 8'h10, 8'h00, 8'h03}, 0);
        chk("csum reload done", 32'(dn8), 32'd1);
`else
        do_restart();
        send({8'h01, 8'h00, 8'h13, 8'h00, 8'h10, 8'h00}, 0);
        chk("reload done", 32'(dn8), 32'd1);
        chk("reload word0", mem8[0], 32'h00100013);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/boot_loader.md
# boot_loader

Program loader on the boot path of the RISC-V CPU: it consumes a byte stream over a valid/ready interface, assembles little-endian 32-bit words and writes them into instruction memory. The CPU core is held in reset until the whole image is loaded. The block replaces the bench-driven fixed reset pulse with a controlled release. It is the writer side of the instruction memory the core fetches from.

## Interface
Parameters:
- ADDR_W, 8, instruction-memory word-address width; depth = 2^ADDR_W words

Ports:
- clk  in  1  system clock, rising-edge
- reset  in  1  asynchronous, active-low reset
- in_valid  in  1  byte available on in_data
- in_data  in  8  stream byte
- in_ready  out  1  block accepts a byte this cycle
- restart  in  1  single-cycle request to reload; honoured only in DONE/ERROR
- imem_we  out  1  instruction-memory write strobe, one cycle per word
- imem_addr  out  ADDR_W  word address of current write
- imem_wdata  out  32  word being written
- cpu_reset  out  1  active-high reset to cpu_top
- done  out  1  image loaded successfully
- err  out  1  load failed (overflow or checksum)

## Operation
- Stream format: count_lo, count_hi (16-bit word count N, little-endian), then 4·N data bytes, each word little-endian (first byte → bits[7:0]).
- Handshake: a byte is consumed on a rising edge with in_valid && in_ready. in_ready = 1 in HDR_LO, HDR_HI, DATA, CSUM; 0 in DONE, ERROR. in_data is ignored when not consumed.
- States: HDR_LO → HDR_HI → DATA (N>0) or end-of-stream (N=0) → DONE | ERROR; CSUM inserted before end when configured.
- DATA: byte counter 0..3 shifts bytes into an assembly register. The 4th byte triggers the write and increments the word index. After word N-1, the block goes to end-of-stream.
- Word index ≥ 2^ADDR_W: the word is consumed but not written (imem_we stays 0) and a sticky ovf flag is set. The address does not wrap.
- End-of-stream: go to ERROR if ovf (or checksum mismatch), otherwise go to DONE.
- DONE: done=1, err=0, cpu_reset deasserted. ERROR: err=1, done=0, cpu_reset stays 1.
- restart in DONE/ERROR: next edge enters HDR_LO, clears done/err/ovf, word index = 0, and reasserts cpu_reset. restart is ignored in other states.
- Reset (async, mid-operation included): state HDR_LO, counters 0, partial word discarded.

## Timing
- Reset values: in_ready=1, imem_we=0, imem_addr=0, imem_wdata=0, cpu_reset=1, done=0, err=0. cpu_reset asserts asynchronously with reset.
- imem_we/imem_addr/imem_wdata are registered. They are valid in the cycle after the edge consuming a word's 4th byte, for exactly one cycle.
- done/err assert in the cycle after the edge consuming the final stream byte.
- cpu_reset falls one cycle after done rises, so the last write completes before the core leaves reset.
- Back-to-back bytes at full rate are accepted with no bubbles. Max one write per 4 cycles.
- On restart, cpu_reset=1 and done=0 in the cycle after the restart edge.

## Configuration
- BOOT_CHECKSUM_EN defined: one extra byte follows the data (state CSUM, also entered directly after the header when N=0). It must equal the XOR of all 4·N data bytes (seed 0x00). On mismatch → ERROR.
- BOOT_CHECKSUM_EN undefined: no CSUM state. End-of-stream follows the last data byte (or the header when N=0).

## Test plan
- Reset check: reset low mid-word (after 2 data bytes) → all outputs return to reset values immediately. The next stream 01 00 13 00 10 00 writes 0x00100013 at addr 0.
- Load 3 words (03 00, then 0x00100093, 0x00200113, 0x002081B3 as LE bytes) at full rate → imem_we at addr 0,1,2 with those words. done=1, then cpu_reset=0 one cycle later. Running the core afterwards gives x1=1, x2=2, x3=3.
- Throttling: in_valid toggling every other cycle → identical writes. No byte is consumed while in_valid=0.
- N=0 (00 00) → no imem_we, done=1. With BOOT_CHECKSUM_EN, CSUM byte 00 is also required.
- ADDR_W=2, N=5 → 4 writes (addr 0-3), 5th word consumed with no write. err=1, cpu_reset stays 1, in_ready=0.
- BOOT_CHECKSUM_EN: 1 word 0x00100013 with CSUM 0x03 → done. With CSUM 0x04 → err. Then pulse restart → cpu_reset=1, in_ready=1, and a reload succeeds.
